// File: rtl/seq_serializer_if.sv
// seq_serializer_if: word-load handshake plus serial-stream outputs of the
// seq_serializer block.
//   load_data   - parallel word offered by the producer
//   load_valid  - load_data is valid
//   load_ready  - serializer can take a word this cycle
//   seq_out     - serial bit stream toward the sequence detector
//   seq_valid   - seq_out carries a data bit
//   frame_start - first bit of a word is on seq_out
//   frame_end   - last bit of a word is on seq_out
//   state_out   - encoded FSM state (0 = IDLE, 1 = SHIFT)
// modport slave is the serializer; modport master is the producer/monitor side.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             seq_out;
  logic             seq_valid;
  logic             frame_start;
  logic             frame_end;
  logic [1:0]       state_out;

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output seq_out,
    output seq_valid,
    output frame_start,
    output frame_end,
    output state_out
  );

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  seq_out,
    input  seq_valid,
    input  frame_start,
    input  frame_end,
    input  state_out
  );
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial feeder for the sequence-detector stage.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// seq_out. A one-entry pending buffer (plus a last-bit bypass) lets words
// stream back to back with seq_valid held high continuously.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous, active-low reset
//   bus - seq_serializer_if.slave (load handshake, serial stream, strobes)
// Parameters:
//   WIDTH      - bits per word (>= 2)
//   MSB_FIRST  - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_LEVEL - seq_out level while not shifting
module seq_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  seq_serializer_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [WIDTH-1:0] pend_reg, pend_nxt;
  logic             pend_full, pend_full_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_ready;
  logic             accept;

  // Move the next bit onto the output end of the register.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  // Ready depends only on the pending flag and reset, never on load_valid.
  assign load_ready = rst & ~pend_full;
  assign accept     = bus.load_valid & load_ready;

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    cnt_nxt       = cnt;
    pend_nxt      = pend_reg;
    pend_full_nxt = pend_full;
    case (state)
      IDLE: begin
        pend_full_nxt = 1'b0;
        if (accept) begin
          shift_nxt = bus.load_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          shift_nxt = shift_once(shift_reg);
          cnt_nxt   = cnt + CNT_W'(1);
          if (accept) begin
            pend_nxt      = bus.load_data;
            pend_full_nxt = 1'b1;
          end
        end else if (pend_full) begin
          // load_ready is low here, so no word can be accepted this edge.
          shift_nxt     = pend_reg;
          pend_full_nxt = 1'b0;
          cnt_nxt       = '0;
        end else if (accept) begin
          // Word offered on the last bit goes straight into the shifter.
          shift_nxt = bus.load_data;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        pend_full_nxt = 1'b0;
        cnt_nxt       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_full <= 1'b0;
      shift_reg <= '0;
      pend_reg  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend_full <= pend_full_nxt;
      shift_reg <= shift_nxt;
      pend_reg  <= pend_nxt;
    end
  end

  // Outputs decode from registers only.
  assign bus.load_ready  = load_ready;
  assign bus.seq_valid   = (state == SHIFT);
  assign bus.seq_out     = (state == SHIFT) ?
                           (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) :
                           IDLE_LEVEL;
  assign bus.frame_start = (state == SHIFT) && (cnt == '0);
  assign bus.frame_end   = (state == SHIFT) && (cnt == LAST);
  assign bus.state_out   = state;

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: drives one MSB-first and one LSB-first seq_serializer
// from the same load stream and checks both serial outputs against a
// scoreboard filled at each accepted word.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ld  = 8'h00;
  logic       lv  = 1'b0;

  always #5 clk = ~clk;

  seq_serializer_if #(.WIDTH(8)) ifm ();
  seq_serializer_if #(.WIDTH(8)) ifl ();

  assign ifm.load_data  = ld;
  assign ifm.load_valid = lv;
  assign ifl.load_data  = ld;
  assign ifl.load_valid = lv;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (ifm)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (ifl)
  );

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  exp_t qm[$];
  exp_t ql[$];
  exp_t em, el;
  int   n_vec = 0;
  int   n_err = 0;
  int   run_m = 0, run_l = 0, last_run_m = 0, last_run_l = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Main process works at negedge + 1.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.fs = (i == 0);
      e.fe = (i == 7);
      e.b  = w[7-i];
      qm.push_back(e);
      e.b  = w[i];
      ql.push_back(e);
    end
  endtask

  // Offers w and leaves load_valid high; returns one cycle after acceptance.
  task automatic send(input logic [7:0] w);
    logic r;
    int   n;
    ld = w;
    lv = 1'b1;
    n  = 0;
    forever begin
      r = ifm.load_ready;
      @(posedge clk);
      if (r) break;
      #1;
      @(negedge clk);
      #1;
      n++;
      if (n > 100) break;
    end
    if (n > 100) check("send_timeout", 0, 1);
    else push_word(w);
    step();
  endtask

  // Waits for the stream to stop, then checks run length and empty scoreboard.
  task automatic drain(input int exp_run);
    int n;
    n = 0;
    while (ifm.seq_valid === 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("drain_timeout", 0, 1);
    check("m_run_len", last_run_m, exp_run);
    check("l_run_len", last_run_l, exp_run);
    check("m_sb_empty", qm.size(), 0);
    check("l_sb_empty", ql.size(), 0);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (ifm.seq_valid === 1'b1) begin
      run_m++;
      check("m_state", ifm.state_out, 1);
      if (qm.size() == 0) check("m_extra_bit", 1, 0);
      else begin
        em = qm.pop_front();
        check("m_bit", ifm.seq_out, em.b);
        check("m_fs", ifm.frame_start, em.fs);
        check("m_fe", ifm.frame_end, em.fe);
      end
    end else begin
      if (run_m != 0) begin
        last_run_m = run_m;
        run_m      = 0;
      end
      check("m_idle", {ifm.seq_out, ifm.frame_start, ifm.frame_end, ifm.state_out}, 0);
    end
  end

  always @(negedge clk) begin
    if (ifl.seq_valid === 1'b1) begin
      run_l++;
      check("l_state", ifl.state_out, 1);
      if (ql.size() == 0) check("l_extra_bit", 1, 0);
      else begin
        el = ql.pop_front();
        check("l_bit", ifl.seq_out, el.b);
        check("l_fs", ifl.frame_start, el.fs);
        check("l_fe", ifl.frame_end, el.fe);
      end
    end else begin
      if (run_l != 0) begin
        last_run_l = run_l;
        run_l      = 0;
      end
      check("l_idle", {ifl.seq_out, ifl.frame_start, ifl.frame_end, ifl.state_out}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a word offered: nothing may be accepted.
    rst = 1'b0;
    lv  = 1'b1;
    ld  = 8'hAA;
    step();
    step();
    check("rst_seq_out", ifm.seq_out, 0);
    check("rst_seq_valid", ifm.seq_valid, 0);
    check("rst_ready_m", ifm.load_ready, 0);
    check("rst_ready_l", ifl.load_ready, 0);
    check("rst_state", ifm.state_out, 0);
    lv  = 1'b0;
    rst = 1'b1;
    #1;
    check("rel_ready_m", ifm.load_ready, 1);
    check("rel_ready_l", ifl.load_ready, 1);
    step();
    step();
    check("no_accept", ifm.seq_valid, 0);

    // Single word.
    send(8'hF7);
    lv = 1'b0;
    check("latency_valid", ifm.seq_valid, 1);
    check("latency_fs", ifm.frame_start, 1);
    drain(8);

    // Back-to-back through the pending buffer.
    step();
    send(8'hF7);
    lv = 1'b0;
    repeat (3) step();
    send(8'h6D);
    lv = 1'b0;
    check("pend_ready0", ifm.load_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("pend_ready_low", ifm.load_ready, 0);
    end
    step();
    check("pend_ready_back", ifm.load_ready, 1);
    drain(16);

    // Bypass on the last bit.
    step();
    send(8'hF7);
    lv = 1'b0;
    repeat (7) step();
    check("byp_fe_cycle", ifm.frame_end, 1);
    check("byp_ready", ifm.load_ready, 1);
    send(8'hB6);
    lv = 1'b0;
    check("byp_first_bit", ifm.seq_out, 1);
    check("byp_first_fs", ifm.frame_start, 1);
    drain(16);

    // Backpressure with load_valid held continuously.
    step();
    send(8'h3C);
    send(8'hA5);
    send(8'h5A);
    lv = 1'b0;
    drain(24);

    // Reset in the middle of a word.
    step();
    send(8'hF7);
    lv = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    #1;
    check("midrst_valid", ifm.seq_valid, 0);
    check("midrst_out", ifm.seq_out, 0);
    check("midrst_state", ifl.state_out, 0);
    check("midrst_ready", ifm.load_ready, 0);
    qm.delete();
    ql.delete();
    step();
    step();
    rst = 1'b1;
    step();
    send(8'h81);
    lv = 1'b0;
    drain(8);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
